// File: rtl/axis_switch_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_switch_sched_pkg
//  Description : Shared types and reset constants for the AXIS switch
//                channel sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_switch_sched_pkg;

    // Build-time geometry; the table entry layout below is sized from these.
    localparam int c_N     = 16;
    localparam int c_DEPTH = 16;
    localparam int c_DW    = 16;
    localparam int c_CW    = $clog2(c_N);
    localparam int c_AW    = $clog2(c_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [c_CW-1:0] ch;
        logic [c_DW-1:0] dwell;
    } entry_t;

    localparam state_t           c_rst_state   = ST_IDLE;
    localparam logic [c_CW-1:0]  c_rst_ch_sel  = '0;
    localparam logic [c_AW-1:0]  c_rst_idx     = '0;
    localparam logic             c_rst_blank   = 1'b0;
    localparam logic             c_rst_active  = 1'b0;
    localparam logic             c_rst_done    = 1'b0;

endpackage
`default_nettype wire

// File: rtl/axis_switch_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_switch_sched_if
//  Description : Table-programming, control and channel-select bundle of the
//                AXIS switch channel sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_switch_sched_if #(
    parameter int N     = 16,
    parameter int DEPTH = 16,
    parameter int DW    = 16
);
    localparam int CW = $clog2(N);
    localparam int AW = $clog2(DEPTH);

    logic          tbl_we;
    logic [AW-1:0] tbl_addr;
    logic [CW-1:0] tbl_ch;
    logic [DW-1:0] tbl_dwell;
    logic [AW:0]   n_entries;
    logic          loop;
    logic          start;
    logic          stop;
    logic [CW-1:0] ch_sel;
    logic          blank;
    logic          active;
    logic [AW-1:0] entry_idx;
    logic          done;

    // Controller side: programs the table and issues run requests.
    modport master (
        output tbl_we, tbl_addr, tbl_ch, tbl_dwell, n_entries, loop, start, stop,
        input  ch_sel, blank, active, entry_idx, done
    );

    // Sequencer side.
    modport slave (
        input  tbl_we, tbl_addr, tbl_ch, tbl_dwell, n_entries, loop, start, stop,
        output ch_sel, blank, active, entry_idx, done
    );
endinterface
`default_nettype wire

// File: rtl/axis_switch_sched_tbl.sv
`default_nettype none
// ============================================================================
//  Module      : axis_switch_sched_tbl
//  Description : Entry table: synchronous write, asynchronous read, cleared
//                by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_switch_sched_tbl
    import axis_switch_sched_pkg::*;
#(
    parameter int DEPTH = c_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          aclk,
    input  wire logic          areset,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire entry_t        wdata,
    input  wire logic [AW-1:0] raddr,
    output entry_t             rdata
);

    entry_t r_mem [DEPTH];

    // Reset clears every entry; otherwise a strobed write updates one entry.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/axis_switch_sched.sv
`default_nettype none
// ============================================================================
//  Module      : axis_switch_sched
//  Description : Walks the entry table, driving the switch channel select for
//                each entry's dwell and blanking the stream on channel changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_switch_sched
    import axis_switch_sched_pkg::*;
#(
    parameter int N     = c_N,
    parameter int DEPTH = c_DEPTH,
    parameter int DW    = c_DW,
    parameter int GUARD = 2
) (
    input  wire logic          aclk,
    input  wire logic          areset,
    axis_switch_sched_if.slave bus
);

    localparam int             CW      = $clog2(N);
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [CW:0]    c_n_lim = (CW+1)'(N);
    localparam logic [DW-1:0]  c_guard = DW'(GUARD);

    state_t        r_state,  w_state_nx;
    logic [AW-1:0] r_idx,    w_idx_nx;
    logic [AW:0]   r_n,      w_n_nx;
    logic          r_loop,   w_loop_nx;
    logic [DW-1:0] r_cnt,    w_cnt_nx;     // cycles left in the entry, incl. current
    logic [DW-1:0] r_brem,   w_brem_nx;    // blank cycles left, incl. current
    logic [CW-1:0] r_ch_sel, w_ch_nx;
    logic          r_blank,  w_blank_nx;
    logic          r_active, w_active_nx;
    logic          r_done,   w_done_nx;
    logic          w_load;

    entry_t        w_tbl_wdata;
    entry_t        w_rd_ent;
    logic [AW-1:0] w_rd_addr;
    logic          w_last_entry;
    logic [DW-1:0] w_dwell_eff;
    logic [DW-1:0] w_guard_len;
    logic          w_oor;

    assign w_tbl_wdata = '{ch: bus.tbl_ch, dwell: bus.tbl_dwell};

    axis_switch_sched_tbl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tbl (
        .aclk   (aclk),
        .areset (areset),
        .we     (bus.tbl_we),
        .waddr  (bus.tbl_addr),
        .wdata  (w_tbl_wdata),
        .raddr  (w_rd_addr),
        .rdata  (w_rd_ent)
    );

    // The entry that would start next: 0 from IDLE or on wrap, else idx+1.
    assign w_last_entry = ({1'b0, r_idx} == (r_n - (AW+1)'(1)));
    assign w_rd_addr    = (r_state == ST_RUN && !w_last_entry) ? r_idx + AW'(1) : '0;
    assign w_dwell_eff  = (w_rd_ent.dwell == '0) ? DW'(1) : w_rd_ent.dwell;
    assign w_guard_len  = (w_dwell_eff < c_guard) ? w_dwell_eff : c_guard;
    assign w_oor        = ({1'b0, w_rd_ent.ch} >= c_n_lim);

    // Next-state and next-output decode; an entry start is folded into w_load.
    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_n_nx      = r_n;
        w_loop_nx   = r_loop;
        w_cnt_nx    = r_cnt;
        w_brem_nx   = r_brem;
        w_ch_nx     = r_ch_sel;
        w_blank_nx  = 1'b0;
        w_active_nx = r_active;
        w_done_nx   = 1'b0;
        w_load      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.stop && (bus.n_entries != '0)) begin
                    w_load     = 1'b1;
                    w_n_nx     = bus.n_entries;
                    w_loop_nx  = bus.loop;
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    w_state_nx  = ST_IDLE;
                    w_active_nx = 1'b0;
                    w_brem_nx   = '0;
                end else if (r_cnt == DW'(1)) begin
                    if (w_last_entry && !r_loop) begin
                        w_state_nx  = ST_IDLE;
                        w_active_nx = 1'b0;
                        w_done_nx   = 1'b1;
                        w_brem_nx   = '0;
                    end else begin
                        w_load = 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt - DW'(1);
                    if (r_brem != '0) begin
                        w_brem_nx = r_brem - DW'(1);
                    end
                    w_blank_nx = (w_brem_nx != '0);
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        // Entry start: out-of-range channels keep the select and blank throughout.
        if (w_load) begin
            w_active_nx = 1'b1;
            w_idx_nx    = w_rd_addr;
            w_cnt_nx    = w_dwell_eff;
            if (w_oor) begin
                w_brem_nx = w_dwell_eff;
            end else begin
                w_ch_nx   = w_rd_ent.ch;
                w_brem_nx = (w_rd_ent.ch != r_ch_sel) ? w_guard_len : '0;
            end
            w_blank_nx = (w_brem_nx != '0);
        end
    end

    // State, counters and all outputs are registered here.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= c_rst_state;
            r_idx    <= AW'(c_rst_idx);
            r_n      <= '0;
            r_loop   <= 1'b0;
            r_cnt    <= '0;
            r_brem   <= '0;
            r_ch_sel <= CW'(c_rst_ch_sel);
            r_blank  <= c_rst_blank;
            r_active <= c_rst_active;
            r_done   <= c_rst_done;
        end else begin
            r_state  <= w_state_nx;
            r_idx    <= w_idx_nx;
            r_n      <= w_n_nx;
            r_loop   <= w_loop_nx;
            r_cnt    <= w_cnt_nx;
            r_brem   <= w_brem_nx;
            r_ch_sel <= w_ch_nx;
            r_blank  <= w_blank_nx;
            r_active <= w_active_nx;
            r_done   <= w_done_nx;
        end
    end

    assign bus.ch_sel    = r_ch_sel;
    assign bus.blank     = r_blank;
    assign bus.active    = r_active;
    assign bus.entry_idx = r_idx;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_axis_switch_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_switch_sched
//  Description : Self-checking bench for axis_switch_sched; every cycle is
//                compared with a schedule-expansion reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_switch_sched;

    localparam int NCH   = 12;
    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int GUARD = 2;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    axis_switch_sched_if #(.N(NCH), .DEPTH(DEPTH), .DW(DW)) bus ();

    axis_switch_sched #(
        .N     (NCH),
        .DEPTH (DEPTH),
        .DW    (DW),
        .GUARD (GUARD)
    ) dut (
        .aclk   (clk),
        .areset (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: on each entry start the entry is expanded into its
    // per-cycle (ch_sel, blank) schedule; cycles are then consumed one by one.
    typedef struct {
        int ch;
        bit blank;
    } rec_t;

    rec_t m_q[$];
    int   m_tch [DEPTH];
    int   m_tdw [DEPTH];
    bit   m_run;
    int   m_n;
    bit   m_loop;
    int   m_ch, m_idx;
    bit   m_blank, m_active, m_done;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic begin_entry(input int i);
        int ch;
        int dw;
        int g;
        ch = m_tch[i];
        dw = (m_tdw[i] == 0) ? 1 : m_tdw[i];
        m_idx    = i;
        m_active = 1'b1;
        if (ch >= NCH) begin
            for (int k = 0; k < dw; k++) m_q.push_back('{ch: m_ch, blank: 1'b1});
        end else begin
            g = (ch != m_ch) ? ((GUARD < dw) ? GUARD : dw) : 0;
            for (int k = 0; k < dw; k++) m_q.push_back('{ch: ch, blank: (k < g)});
        end
    endtask

    task automatic model_step();
        rec_t r;
        if (rst) begin
            m_run = 0; m_q.delete();
            m_ch = 0; m_idx = 0; m_blank = 0; m_active = 0; m_done = 0;
            for (int i = 0; i < DEPTH; i++) begin m_tch[i] = 0; m_tdw[i] = 0; end
            return;
        end
        m_done = 0;
        if (!m_run) begin
            m_blank = 0;
            if (bus.start && !bus.stop && bus.n_entries != 0) begin
                m_run  = 1;
                m_n    = int'(bus.n_entries);
                m_loop = bus.loop;
                begin_entry(0);
            end
        end else if (bus.stop) begin
            m_run = 0; m_active = 0; m_blank = 0; m_q.delete();
        end else if (m_q.size() == 0) begin
            if (m_idx == m_n - 1) begin
                if (m_loop) begin_entry(0);
                else begin
                    m_run = 0; m_active = 0; m_blank = 0; m_done = 1;
                end
            end else begin
                begin_entry(m_idx + 1);
            end
        end
        if (m_run) begin
            r = m_q.pop_front();
            m_ch    = r.ch;
            m_blank = r.blank;
        end
        if (bus.tbl_we) begin
            m_tch[bus.tbl_addr] = int'(bus.tbl_ch);
            m_tdw[bus.tbl_addr] = int'(bus.tbl_dwell);
        end
    endtask

    // One clock: model advances on the same edge, DUT sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("ch_sel",    32'(bus.ch_sel),    m_ch);
        chk("blank",     32'(bus.blank),     int'(m_blank));
        chk("active",    32'(bus.active),    int'(m_active));
        chk("entry_idx", 32'(bus.entry_idx), m_idx);
        chk("done",      32'(bus.done),      int'(m_done));
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic wr(input int a, input int ch, input int dw);
        bus.tbl_we = 1'b1; bus.tbl_addr = 4'(a); bus.tbl_ch = 4'(ch); bus.tbl_dwell = 16'(dw);
        step();
        bus.tbl_we = 1'b0;
    endtask

    task automatic go(input int n, input bit lp);
        bus.n_entries = 5'(n); bus.loop = lp; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        int k;
        n_chk = 0; n_err = 0;
        rst = 1'b1;
        bus.tbl_we = 0; bus.tbl_addr = 0; bus.tbl_ch = 0; bus.tbl_dwell = 0;
        bus.n_entries = 0; bus.loop = 0; bus.start = 0; bus.stop = 0;
        steps(2);
        rst = 1'b0;
        chk("rst_ch_sel", 32'(bus.ch_sel), 0);
        chk("rst_active", 32'(bus.active), 0);
        step();

        // Single pass with dwell-0 entry and completion latency.
        wr(0, 3, 4); wr(1, 7, 1); wr(2, 3, 0);
        go(3, 0);
        k = 1;
        while (!bus.done && k < 20) begin step(); k++; end
        chk("done_latency", 32'(k), 7);
        steps(2);

        // n_entries = 0 and start+stop together must not run.
        go(0, 0); steps(3);
        bus.stop = 1'b1; go(3, 0); bus.stop = 1'b0; steps(2);
        chk("idle_after_start_stop", 32'(bus.active), 0);

        // Loop, restart attempt while running, then stop mid-entry.
        wr(0, 1, 2); wr(1, 2, 2);
        go(2, 1); steps(5);
        go(3, 0); steps(4);
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
        steps(3);

        // Out-of-range channel sits between two valid entries.
        wr(0, 5, 2); wr(1, 13, 5); wr(2, 6, 3);
        go(3, 0); steps(12);

        // Rewrite the running entry; change shows on the next pass only.
        wr(0, 1, 3); wr(1, 2, 3);
        go(2, 1); step();
        wr(0, 4, 2);
        steps(12);
        bus.stop = 1'b1; step(); bus.stop = 1'b0;

        // Reset mid-run, then a fresh start from a cleared table.
        wr(0, 9, 3);
        go(1, 1); steps(2);
        rst = 1'b1; step(); rst = 1'b0;
        wr(0, 2, 2);
        go(1, 0); steps(4);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            bus.tbl_we    = ($urandom_range(0, 3) == 0);
            bus.tbl_addr  = 4'($urandom_range(0, 5));
            bus.tbl_ch    = 4'($urandom_range(0, 15));
            bus.tbl_dwell = 16'($urandom_range(0, 5));
            bus.n_entries = 5'($urandom_range(0, 5));
            bus.loop      = 1'($urandom_range(0, 1));
            bus.start     = ($urandom_range(0, 9) == 0);
            bus.stop      = ($urandom_range(0, 39) == 0);
            rst           = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 0; bus.tbl_we = 0; bus.start = 0; bus.stop = 0;
        steps(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_switch_sched.md
# axis_switch_sched

Hardware channel sequencer for the AXIS one-to-N switch. A small table holds entries of (output channel, dwell cycles). On `start`, the block walks the table and drives the switch's channel select, holding each channel for its programmed dwell. It runs once or loops, and blanks the stream around channel changes. It sits beside the switch in the `aclk` domain and replaces the register-driven channel select when sequenced routing is needed.

## Interface
- `N`, 16: number of switch outputs; channel field width `CW = $clog2(N)`.
- `DEPTH`, 16: table entries; index width `AW = $clog2(DEPTH)`.
- `DW`, 16: dwell counter width.
- `GUARD`, 2: blank cycles at the start of each entry whose channel differs from the currently applied one.

Ports:
- `aclk`  in  1  clock.
- `areset`  in  1  synchronous, active-high reset.
- `tbl_we`  in  1  table write strobe.
- `tbl_addr`  in  AW  table write address.
- `tbl_ch`  in  CW  channel written to the entry.
- `tbl_dwell`  in  DW  dwell written to the entry.
- `n_entries`  in  AW+1  number of entries to run, latched at start.
- `loop`  in  1  when 1, wrap to entry 0 after the last entry; latched at start.
- `start`  in  1  single-cycle run request.
- `stop`  in  1  abort request.
- `ch_sel`  out  CW  channel select to the switch.
- `blank`  out  1  when 1, the switch output tvalid must be gated low.
- `active`  out  1  sequence running.
- `entry_idx`  out  AW  index of the entry currently applied.
- `done`  out  1  one-cycle pulse on normal (non-loop) completion.

## Operation
- FSM states: IDLE and RUN.
- IDLE → RUN on `start` when `n_entries` ≠ 0. `start` with `n_entries` = 0 is ignored and `done` does not pulse.
- Entry start (first entry, each subsequent entry, or loop wrap):
  - latch table[idx] into run registers;
  - dwell counter loads `max(dwell,1)` (dwell 0 behaves as 1);
  - set `ch_sel` = ch;
  - set `blank` for `min(GUARD, dwell)` cycles if ch ≠ the previous `ch_sel`.
- Out-of-range entry (ch ≥ N):
  - `ch_sel` is unchanged;
  - `blank` stays 1 for the whole dwell;
  - the entry still consumes its dwell.
- After the last cycle of entry n_entries−1:
  - if `loop`, the next entry is 0;
  - otherwise → IDLE, `done`=1 for one cycle, `active`=0.
- `stop` in RUN → IDLE next cycle. No `done` pulse; `ch_sel` holds its value and `blank` clears.
- `start` during RUN is ignored. In IDLE, if `start` and `stop` assert together, `stop` wins.
- Table writes are allowed at any time. A write to the running entry takes effect at that entry's next start; the run registers are not disturbed.
- Reset values:
  - `ch_sel`=0, `blank`=0, `active`=0, `entry_idx`=0, `done`=0, FSM=IDLE;
  - table contents are cleared to 0;
  - reset mid-run aborts immediately with the same values.

## Timing
- `start` sampled high at edge t: at t+1, `active`=1, `entry_idx`=0, `ch_sel`=table[0].ch.
- Entry k occupies exactly `max(D_k,1)` consecutive cycles, with no gap cycles between entries or on wrap.
- Completion: the cycle after the last dwell cycle has `active`=0 and `done`=1. `ch_sel` keeps the last channel.
- `blank` is registered and coincident with the `ch_sel` change. It is never asserted in IDLE.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `tbl_we` at edge t: the new value is readable by an entry start at t+1 or later.

## Structure
- Package `axis_switch_sched_pkg` holds:
  - the `state_t` enum (IDLE, RUN);
  - the `entry_t` struct (ch, dwell);
  - the reset constants.
- Sub-module `axis_switch_sched_tbl` is a DEPTH×(CW+DW) register file with synchronous write, asynchronous read and clear on `areset`.
- The top level contains the FSM, index/dwell counters, blank counter and output registers.

## Test plan
- Single pass:
  - program {(3,4),(7,1),(3,0)}, `n_entries`=3, `loop`=0, `start`;
  - required: `ch_sel` = 3×4, 7×1, 3×1 cycles, then `done` pulses at cycle 7 after start;
  - `blank` is high for 2 cycles at ch 3 (previous 0), 1 cycle at ch 7, and 1 cycle at the return to 3.
- Loop + stop:
  - `loop`=1 with 2 entries (1,2),(2,2);
  - required: the pattern 1,1,2,2 repeats without gaps;
  - `stop` mid-entry gives `active`=0 next cycle, no `done`, and `ch_sel` holds.
- Boundaries:
  - `n_entries`=0 `start` → no activity;
  - `start`+`stop` together in IDLE → stays IDLE;
  - `start` during RUN → no restart.
- Out-of-range entry:
  - N=12, entry (13,5);
  - required: `ch_sel` unchanged and `blank`=1 for 5 cycles, then the next entry proceeds.
- Live table write and reset:
  - rewrite the running entry → the change appears only on its next pass;
  - `areset` mid-run → all outputs 0 next cycle, then a fresh `start` runs entry 0.
